// File: rtl/booth_seq_divider32.sv
// Iterative restoring divider: one quotient bit per clock, fixed 34-cycle latency
// from start acceptance to the out_valid pulse, signed or unsigned operands.
module booth_seq_divider32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             alu_signed,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] QUOT,
    output logic [WIDTH-1:0] REM,
    output logic             div_zero
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_mag_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] q_res_reg;
    logic [WIDTH-1:0] r_res_reg;
    logic             sign_q_reg;
    logic             sign_r_reg;
    logic             dz_reg;
    logic             ovf_reg;

    // Operand 0 is the dividend, operand 1 the divisor.
    logic [WIDTH-1:0] op_raw [2];
    logic [WIDTH-1:0] op_mag [2];
    logic [1:0]       op_neg;

    assign op_raw[0] = A;
    assign op_raw[1] = B;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mag
            assign op_neg[gi] = alu_signed & op_raw[gi][WIDTH-1];
            assign op_mag[gi] = op_neg[gi] ? (~op_raw[gi] + WIDTH'(1)) : op_raw[gi];
        end
    endgenerate

    // The shifted partial remainder is one bit wider than the divisor so that
    // divisors with the MSB set still compare correctly in unsigned mode.
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_trial;
    logic             no_borrow;

    always_comb begin
        shifted   = {rem_reg, quo_reg[WIDTH-1]};
        no_borrow = (shifted >= {1'b0, b_mag_reg});
        rem_trial = shifted[WIDTH-1:0] - b_mag_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            a_reg      <= '0;
            b_mag_reg  <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            q_res_reg  <= '0;
            r_res_reg  <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            dz_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            QUOT       <= '0;
            REM        <= '0;
            div_zero   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_reg      <= A;
                        b_mag_reg  <= op_mag[1];
                        quo_reg    <= op_mag[0];
                        rem_reg    <= '0;
                        sign_q_reg <= op_neg[0] ^ op_neg[1];
                        sign_r_reg <= op_neg[0];
                        dz_reg     <= (B == '0);
                        ovf_reg    <= alu_signed && (A == MIN_NEG) && (B == '1);
                        count_reg  <= '0;
                        busy       <= 1'b1;
                        state_reg  <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem_reg   <= no_borrow ? rem_trial : shifted[WIDTH-1:0];
                    quo_reg   <= {quo_reg[WIDTH-2:0], no_borrow};
                    count_reg <= count_reg + CNT_W'(1);
                    if (count_reg == LAST_STEP) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Special cases take priority over the sign fix-up.
                    if (dz_reg) begin
                        q_res_reg <= '1;
                        r_res_reg <= a_reg;
                    end else if (ovf_reg) begin
                        q_res_reg <= MIN_NEG;
                        r_res_reg <= '0;
                    end else begin
                        q_res_reg <= sign_q_reg ? (~quo_reg + WIDTH'(1)) : quo_reg;
                        r_res_reg <= sign_r_reg ? (~rem_reg + WIDTH'(1)) : rem_reg;
                    end
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    QUOT      <= q_res_reg;
                    REM       <= r_res_reg;
                    div_zero  <= dz_reg;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_divider32.sv
// Bench for booth_seq_divider32: directed special cases plus back-to-back random
// operations, all checked cycle by cycle against an arithmetic reference model.
module tb_booth_seq_divider32;
    localparam int LAT  = 34;
    localparam int MAXT = 1100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        alu_signed = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        out_valid;
    logic        div_zero;
    logic [31:0] QUOT;
    logic [31:0] REM;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Issue log written only by the driver; the checker retires entries in order.
    logic [31:0] t_a [MAXT];
    logic [31:0] t_b [MAXT];
    logic [31:0] t_lq [MAXT];
    logic [31:0] t_lr [MAXT];
    logic        t_s [MAXT];
    logic        t_lit [MAXT];
    logic        t_ldz [MAXT];
    int          t_due [MAXT];
    int          n_issued = 0;
    int          rd = 0;

    logic [31:0] hold_q = '0;
    logic [31:0] hold_r = '0;
    logic        hold_dz = 1'b0;

    booth_seq_divider32 #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (A),
        .B          (B),
        .alu_signed (alu_signed),
        .busy       (busy),
        .out_valid  (out_valid),
        .QUOT       (QUOT),
        .REM        (REM),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division with the two documented overrides.
    function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        dz = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {dz, q, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %08h, expected %08h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [64:0] m;
        logic        ev;
        logic        eb;
        int          due;
        if (rst) begin
            rd      = n_issued;
            hold_q  = '0;
            hold_r  = '0;
            hold_dz = 1'b0;
        end
        ev = 1'b0;
        eb = 1'b0;
        if (rd < n_issued) begin
            due = t_due[rd];
            ev  = (cyc == due);
            eb  = (cyc >= due - LAT) && (cyc < due);
        end
        chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
        chk("busy", {31'b0, busy}, {31'b0, eb});
        if (ev) begin
            m       = ref_div(t_a[rd], t_b[rd], t_s[rd]);
            hold_q  = m[63:32];
            hold_r  = m[31:0];
            hold_dz = m[64];
            if (t_lit[rd]) begin
                chk("model_quot", m[63:32], t_lq[rd]);
                chk("model_rem", m[31:0], t_lr[rd]);
                chk("model_dz", {31'b0, m[64]}, {31'b0, t_ldz[rd]});
                chk("lit_quot", QUOT, t_lq[rd]);
                chk("lit_rem", REM, t_lr[rd]);
                chk("lit_dz", {31'b0, div_zero}, {31'b0, t_ldz[rd]});
            end
            $display("txn %0d a=%08h b=%08h signed=%0d quot=%08h rem=%08h dz=%0d",
                     rd, t_a[rd], t_b[rd], t_s[rd], QUOT, REM, div_zero);
            rd++;
        end
        chk("quot", QUOT, hold_q);
        chk("rem", REM, hold_r);
        chk("div_zero", {31'b0, div_zero}, {31'b0, hold_dz});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Presents start for exactly one edge; operands are scrambled afterwards.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic lit, input logic [31:0] lq, input logic [31:0] lr,
                         input logic ldz);
        A          = a;
        B          = b;
        alu_signed = s;
        start      = 1'b1;
        t_a[n_issued]   = a;
        t_b[n_issued]   = b;
        t_s[n_issued]   = s;
        t_lit[n_issued] = lit;
        t_lq[n_issued]  = lq;
        t_lr[n_issued]  = lr;
        t_ldz[n_issued] = ldz;
        t_due[n_issued] = cyc + 1 + LAT;
        n_issued++;
        tick();
        start      = 1'b0;
        A          = $urandom;
        B          = $urandom;
        alu_signed = 1'($urandom);
    endtask

    // Returns so that the next issue lands on the earliest legal edge.
    task automatic finish_txn();
        while (cyc < t_due[n_issued-1]) tick();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        issue(32'd100, 32'd7, 1'b0, 1'b1, 32'h0000_000E, 32'h0000_0002, 1'b0); finish_txn();
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0); finish_txn();
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0); finish_txn();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 1'b0); finish_txn();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 1'b0); finish_txn();
        issue(32'h1234_5678, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1); finish_txn();
        issue(32'h1234_5678, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1); finish_txn();
        issue(32'hFFFF_FF00, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1); finish_txn();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd1, 32'd0, 1'b0); finish_txn();

        // A second start while busy must be ignored.
        issue(32'd1000, 32'd3, 1'b0, 1'b1, 32'h0000_014D, 32'd1, 1'b0);
        while (cyc < t_due[n_issued-1] - LAT + 9) tick();
        A = 32'd99; B = 32'd5; alu_signed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        finish_txn();

        // Abort mid-operation, then confirm a fresh operation still works.
        issue(32'd12345, 32'd67, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        while (cyc < t_due[n_issued-1] - LAT + 20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (40) tick();
        issue(32'd500, 32'hFFFF_FFFD, 1'b1, 1'b1, 32'hFFFF_FF5A, 32'd2, 1'b0); finish_txn();

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 15));
                4: b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            issue(a, b, 1'($urandom), 1'b0, 32'd0, 32'd0, 1'b0);
            finish_txn();
        end

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/booth_seq_divider32.md
Name: booth_seq_divider32

Overview:
- Iterative 32/32 integer divider; the inverse companion of the single-cycle 32x32 Booth multiplier in the ALU datapath.
- Produces a quotient and a remainder for signed or unsigned operands, retiring one restoring-division bit per clock.
- Uses a start/busy/valid handshake so the ALU issue logic can stall on it.
- Sign control matches the multiplier (`alu_signed`), so both units share operand muxing.

Parameters:
- WIDTH, 32, operand/quotient/remainder width; only 32 is verified.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  dividend
- B  input  WIDTH  divisor
- alu_signed  input  1  1 = two's-complement operands, 0 = unsigned
- busy  output  1  high from the cycle after start acceptance until out_valid
- out_valid  output  1  one-cycle pulse; QUOT/REM valid
- QUOT  output  WIDTH  quotient
- REM  output  WIDTH  remainder
- div_zero  output  1  set with out_valid when B was 0

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, out_valid, div_zero = 0; QUOT, REM = 0; internal registers cleared.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - IDLE: if start=1 at edge N, latch A, B and alu_signed. Latch |A| and |B|; magnitudes are taken only when alu_signed=1 and the operand MSB=1. Latch sign flags and the div-by-zero flag. Set count=0 and go to CALC. busy=1 from edge N.
  - CALC: one restoring step per cycle: shift {rem,quo} left by 1, trial-subtract |B| from the upper part, set the quotient LSB on no borrow. Trial subtraction is WIDTH+1 bits wide so unsigned 0xFFFFFFFF operands are handled. After WIDTH steps (edges N+1..N+32) go to FIX.
  - FIX (edge N+33): quotient sign = sA XOR sB; remainder sign = sA (remainder takes the dividend's sign). Apply the negation, then the special-case overrides.
  - DONE (edge N+34): QUOT/REM/div_zero registered, out_valid=1 for exactly one cycle, busy=0. Next state IDLE.
- Latency is fixed at 34 cycles from the start edge to the out_valid edge for every operand combination, including the special cases.
- Throughput: a new start is accepted at the edge where out_valid is high (DONE -> IDLE) or any later edge. The earliest start accepted is therefore at edge N+35.
- QUOT/REM/div_zero hold their values after out_valid until the next DONE or a reset.
- start while busy=1: ignored. Operands are not re-latched and the operation is not restarted.
- Changes to A/B/alu_signed after acceptance have no effect.
- Divide by zero (B=0): QUOT = all ones, REM = A as supplied (unmodified), div_zero=1. This applies to both signed and unsigned.
- Signed overflow (alu_signed=1, A=0x80000000, B=0xFFFFFFFF): QUOT=0x80000000, REM=0, div_zero=0.
- Quotient truncates toward zero. Identity A = QUOT*B + REM (mod 2^32) holds for all non-zero B.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No out_valid is produced for the aborted operation.

Test Plan:
- Unsigned 100/7, start at edge N -> out_valid only at N+34, QUOT=0x0000000E, REM=0x00000002, div_zero=0; busy high edges N..N+33.
- Signed -7/2 (A=0xFFFFFFF9, B=0x00000002) -> QUOT=0xFFFFFFFD, REM=0xFFFFFFFF. Signed 7/-2 -> QUOT=0xFFFFFFFD, REM=0x00000001.
- A=0x80000000, B=0xFFFFFFFF:
  - alu_signed=1 -> QUOT=0x80000000, REM=0.
  - alu_signed=0 -> QUOT=0, REM=0x80000000.
- B=0, A=0x12345678, either mode -> QUOT=0xFFFFFFFF, REM=0x12345678, div_zero=1, latency still 34.
- Busy-start and reset checks:
  - Pulse start with new operands at N+10 -> ignored; result matches the first operands.
  - Assert rst at N+20 -> outputs 0 at once; no out_valid afterwards; a fresh start after reset computes correctly.
- 1000 random operand/mode sets with back-to-back starts at the earliest legal edge -> each result matches the $signed/unsigned `/` and `%` model, and the special-case rules above.
